// File: rtl/inst_req_ctrl.sv
// inst_req_ctrl: instruction-fetch request controller between pre-IF and an
// SRAM-like instruction port. Holds one request until addr_ok, tracks the
// outstanding PCs in order, pairs returning data with its PC and buffers the
// result for IF. A flush cancels everything in flight: already issued
// requests are counted in drop_cnt so their data is discarded on return.
//
// Build option: define INST_REQ_CTRL_OUTSTANDING2_EN to allow two requests in
// flight (MAX_OUT=2). Left undefined, one request is in flight at a time,
// the PC queue is a single register and drop_cnt is one bit.
module inst_req_ctrl #(
  parameter int RESP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fq_valid,
  input  logic [31:0] fq_pc,
  output logic        fq_ready,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_pc,
  output logic [31:0] rsp_inst,
  input  logic        rsp_ready,
  input  logic        flush,
  output logic        busy
);

`ifdef INST_REQ_CTRL_OUTSTANDING2_EN
  localparam int MAX_OUT = 2;
  localparam int DROP_W  = 2;
`else
  localparam int MAX_OUT = 1;
  localparam int DROP_W  = 1;
`endif
  localparam int OUT_W = 2;   // holds 0..MAX_OUT
  localparam int RP_W  = 2;   // response pointers, RESP_DEPTH <= 4
  localparam int RC_W  = 3;   // response count 0..4, also holds out+rsp sums

  localparam logic [OUT_W-1:0] MAX_C   = OUT_W'(MAX_OUT);
  localparam logic [RC_W-1:0]  DEPTH_C = RC_W'(RESP_DEPTH);
  localparam logic [RP_W-1:0]  LAST_P  = RP_W'(RESP_DEPTH - 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t             r_state;
  logic               r_req;
  logic [31:0]        r_addr;
  logic [OUT_W-1:0]   r_out_cnt;
  logic [DROP_W-1:0]  r_drop_cnt;
  logic               r_kill;
  logic [RC_W-1:0]    r_rsp_cnt;
  logic [RP_W-1:0]    r_rb_wp;
  logic [RP_W-1:0]    r_rb_rp;
  logic [31:0]        r_rb_pc   [4];
  logic [31:0]        r_rb_inst [4];

  logic               w_aok;
  logic               w_dok;
  logic               w_drop_now;
  logic               w_push;
  logic               w_pop;
  logic               w_fire;
  logic               w_fq_ready;
  logic [RC_W-1:0]    w_occ;
  logic [OUT_W-1:0]   w_out_nxt;
  logic [31:0]        w_head_pc;

  function automatic logic [RP_W-1:0] ptr_inc(input logic [RP_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // Event decode: a data_ok with nothing outstanding is not an event at all
  assign w_aok      = r_req & inst_sram_addr_ok;
  assign w_dok      = inst_sram_data_ok & (r_out_cnt != '0);
  assign w_drop_now = w_dok & (r_drop_cnt != '0);
  assign w_push     = w_dok & (r_drop_cnt == '0) & ~flush;
  assign w_pop      = rsp_valid & rsp_ready & ~flush;
  assign w_out_nxt  = r_out_cnt + OUT_W'(w_aok) - OUT_W'(w_dok);

  // Credit: every request that can return data must own a free buffer slot
  assign w_occ      = {1'b0, r_out_cnt} + r_rsp_cnt;
  assign w_fq_ready = resetn & (r_state == S_IDLE) & ~flush & (r_out_cnt < MAX_C)
                    & (w_occ < DEPTH_C) & (r_drop_cnt == '0) & ~r_kill;
  assign w_fire     = fq_valid & w_fq_ready;

  assign fq_ready       = w_fq_ready;
  assign inst_sram_req  = r_req;
  assign inst_sram_addr = r_addr;
  assign busy           = r_req | (r_out_cnt != '0);
  assign rsp_valid      = (r_rsp_cnt != '0);
  assign rsp_pc         = rsp_valid ? r_rb_pc[r_rb_rp]   : '0;
  assign rsp_inst       = rsp_valid ? r_rb_inst[r_rb_rp] : '0;

  // Request FSM: the held request/address never change until addr_ok, even on flush
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= fq_pc;
          end
        end
        S_REQ: begin
          if (inst_sram_addr_ok) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Outstanding, drop and kill bookkeeping; a flush drops whatever is still in flight after this cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_kill     <= 1'b0;
    end else begin
      r_out_cnt <= w_out_nxt;
      if (flush) begin
        r_drop_cnt <= DROP_W'(w_out_nxt);
        r_kill     <= r_req & ~inst_sram_addr_ok;
      end else begin
        r_drop_cnt <= r_drop_cnt - DROP_W'(w_drop_now) + DROP_W'(w_aok & r_kill);
        if (w_aok) begin
          r_kill <= 1'b0;
        end
      end
    end
  end

`ifdef INST_REQ_CTRL_OUTSTANDING2_EN
  logic [31:0] r_pcq [2];
  logic        r_pq_wp;
  logic        r_pq_rp;

  // PC queue pointers: written on addr_ok, read on data_ok, untouched by flush
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pq_wp <= 1'b0;
      r_pq_rp <= 1'b0;
    end else begin
      if (w_aok) r_pq_wp <= ~r_pq_wp;
      if (w_dok) r_pq_rp <= ~r_pq_rp;
    end
  end

  // PC queue storage
  always_ff @(posedge clk) begin
    if (w_aok) r_pcq[r_pq_wp] <= r_addr;
  end

  assign w_head_pc = r_pcq[r_pq_rp];
`else
  logic [31:0] r_pcq;

  // Single PC slot for the lone outstanding request
  always_ff @(posedge clk) begin
    if (w_aok) r_pcq <= r_addr;
  end

  assign w_head_pc = r_pcq;
`endif

  // Response buffer control: flush empties it, overriding same-cycle push/pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rb_wp   <= '0;
      r_rb_rp   <= '0;
      r_rsp_cnt <= '0;
    end else if (flush) begin
      r_rb_wp   <= '0;
      r_rb_rp   <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_push) r_rb_wp <= ptr_inc(r_rb_wp);
      if (w_pop)  r_rb_rp <= ptr_inc(r_rb_rp);
      r_rsp_cnt <= r_rsp_cnt + RC_W'(w_push) - RC_W'(w_pop);
    end
  end

  // Response buffer storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rb_pc[r_rb_wp]   <= w_head_pc;
      r_rb_inst[r_rb_wp] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_inst_req_ctrl.sv
// Bench for inst_req_ctrl: directed table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_inst_req_ctrl;
  localparam int DEPTH = 2;
`ifdef INST_REQ_CTRL_OUTSTANDING2_EN
  localparam int MAX_OUT = 2;
`else
  localparam int MAX_OUT = 1;
`endif
  localparam logic M2 = (MAX_OUT == 2);

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fq_valid = 1'b0;
  logic [31:0] fq_pc = '0;
  logic        fq_ready;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_pc;
  logic [31:0] rsp_inst;
  logic        rsp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  inst_req_ctrl #(.RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .fq_valid(fq_valid), .fq_pc(fq_pc), .fq_ready(fq_ready),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .rsp_valid(rsp_valid), .rsp_pc(rsp_pc), .rsp_inst(rsp_inst),
    .rsp_ready(rsp_ready), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: held request, in-order outstanding PCs, drop count, kill, response queue
  typedef struct { logic [31:0] pc; logic [31:0] inst; } rsp_t;
  bit          m_held;
  logic [31:0] m_hpc;
  bit          m_kill;
  int          m_drop;
  logic [31:0] m_pcq[$];
  rsp_t        m_rsp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_hpc = '0; m_kill = 0; m_drop = 0;
    m_pcq.delete(); m_rsp.delete();
  endtask

  function automatic logic m_fq_ready(input logic fl);
    return !m_held && !fl && (m_pcq.size() < MAX_OUT) &&
           ((m_rsp.size() + m_pcq.size()) < DEPTH) && (m_drop == 0) && !m_kill;
  endfunction

  task automatic check_model();
    chk1("fq_ready", fq_ready, m_fq_ready(flush));
    chk1("inst_sram_req", inst_sram_req, m_held);
    if (m_held) chk("inst_sram_addr", inst_sram_addr, m_hpc);
    chk1("rsp_valid", rsp_valid, m_rsp.size() != 0);
    if (m_rsp.size() != 0) begin
      chk("rsp_pc", rsp_pc, m_rsp[0].pc);
      chk("rsp_inst", rsp_inst, m_rsp[0].inst);
    end
    chk1("busy", busy, m_held || (m_pcq.size() != 0));
  endtask

  // Apply the effect of the coming rising edge to the model
  task automatic model_update();
    logic        acc, aok, dok, pop;
    logic [31:0] pc;
    acc = fq_valid && m_fq_ready(flush);
    aok = m_held && inst_sram_addr_ok;
    dok = inst_sram_data_ok && (m_pcq.size() != 0);
    pop = rsp_ready && (m_rsp.size() != 0);
    if (pop && !flush) void'(m_rsp.pop_front());
    if (dok) begin
      pc = m_pcq.pop_front();
      if (m_drop > 0) m_drop--;
      else if (!flush) m_rsp.push_back('{pc, inst_sram_rdata});
    end
    if (aok) begin
      m_pcq.push_back(m_hpc);
      if (m_kill) m_drop++;
      m_kill = 0;
      m_held = 0;
    end
    if (flush) begin
      m_rsp.delete();
      m_drop = m_pcq.size();
      if (m_held) m_kill = 1;
    end
    if (acc) begin
      m_held = 1;
      m_hpc  = fq_pc;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic ao, input logic dk,
                      input logic [31:0] rd, input logic rr, input logic fl);
    @(negedge clk);
    fq_valid = v; fq_pc = pc; inst_sram_addr_ok = ao; inst_sram_data_ok = dk;
    inst_sram_rdata = rd; rsp_ready = rr; flush = fl;
    #1;
    check_model();
    model_update();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_fq_ready"}, fq_ready, 1'b0);
    chk1({tag, "_req"}, inst_sram_req, 1'b0);
    chk({tag, "_addr"}, inst_sram_addr, 32'h0);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_pc"}, rsp_pc, 32'h0);
    chk({tag, "_rsp_inst"}, rsp_inst, 32'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic v; logic [31:0] pc; logic [31:0] rd;
    logic e_rdy; logic e_req; logic [31:0] e_addr;
    logic e_rv; logic [31:0] e_rpc; logic [31:0] e_rinst; logic e_busy;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int bp_acc, bp_pop;

    // Back-to-back fetch, addr_ok/data_ok/rsp_ready always high
    tbl[0] = '{1'b1, 32'h1c000000, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tbl[1] = '{1'b1, 32'h1c000004, 32'h0,        1'b0, 1'b1, 32'h1c000000, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[2] = '{1'b0, 32'h0,        32'hAAAA0000, M2,   1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1};
    tbl[3] = '{1'b1, 32'h1c000004, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000000, 32'hAAAA0000, 1'b0};
    tbl[4] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h1c000004, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[5] = '{1'b0, 32'h0,        32'hBBBB0000, M2,   1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1};
    tbl[6] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000004, 32'hBBBB0000, 1'b0};
    tbl[7] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};

    // Reset state
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].pc, 1'b1, 1'b1, tbl[i].rd, 1'b1, 1'b0);
      chk1($sformatf("tbl%0d_fq_ready", i), fq_ready, tbl[i].e_rdy);
      chk1($sformatf("tbl%0d_req", i), inst_sram_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), inst_sram_addr, tbl[i].e_addr);
      chk1($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        chk($sformatf("tbl%0d_rsp_pc", i), rsp_pc, tbl[i].e_rpc);
        chk($sformatf("tbl%0d_rsp_inst", i), rsp_inst, tbl[i].e_rinst);
      end
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
    end

    // addr_ok stall: request and address hold for 5 cycles
    step(1'b1, 32'h1c000008, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("stall_accept", fq_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h1c00000c, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk1("stall_req", inst_sram_req, 1'b1);
      chk("stall_addr", inst_sram_addr, 32'h1c000008);
      chk1("stall_fq_ready", fq_ready, 1'b0);
    end
    drain(6);

    // Flush while in REQ; addr_ok two cycles later; its data is dropped
    step(1'b1, 32'h1c000200, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("kill_addr_hold", inst_sram_addr, 32'h1c000200);
    step(1'b1, 32'h1c000204, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("kill_fq_ready", fq_ready, 1'b0);
    chk1("kill_req_hold", inst_sram_req, 1'b1);
    step(1'b1, 32'h1c000204, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk1("kill_aok_fq_ready", fq_ready, 1'b0);
    step(1'b1, 32'h1c000204, 1'b0, 1'b1, 32'hCAFE0000, 1'b1, 1'b0);
    chk1("drop_fq_ready", fq_ready, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("kill_rsp_valid", rsp_valid, 1'b0);
    chk1("kill_after_fq_ready", fq_ready, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("kill_rsp_valid2", rsp_valid, 1'b0);

`ifdef INST_REQ_CTRL_OUTSTANDING2_EN
    // Two outstanding then flush: both returning data are discarded
    step(1'b1, 32'h1c000010, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h1c000014, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("out2_second_accept", fq_ready, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h1c000100, 1'b0, 1'b1, 32'hDEAD0001, 1'b1, 1'b0);
    chk1("out2_drop1_fq_ready", fq_ready, 1'b0);
    step(1'b1, 32'h1c000100, 1'b0, 1'b1, 32'hDEAD0002, 1'b1, 1'b0);
    chk1("out2_drop2_fq_ready", fq_ready, 1'b0);
    chk1("out2_drop2_rsp_valid", rsp_valid, 1'b0);
    step(1'b1, 32'h1c000100, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("out2_new_accept", fq_ready, 1'b1);
    chk1("out2_new_rsp_valid", rsp_valid, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("out2_new_addr", inst_sram_addr, 32'h1c000100);
    step(1'b0, '0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("out2_new_rsp_valid2", rsp_valid, 1'b1);
    chk("out2_new_rsp_pc", rsp_pc, 32'h1c000100);
    chk("out2_new_rsp_inst", rsp_inst, 32'h12345678);
`endif

    // Backpressure: no more fetches than buffer slots, nothing lost afterwards
    bp_acc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h1c001000 + 32'(i * 4), 1'b1, 1'b1, $urandom, 1'b0, 1'b0);
      if (fq_ready) bp_acc++;
    end
    chk("bp_accepts", 32'(bp_acc), 32'd2);
    chk1("bp_fq_ready", fq_ready, 1'b0);
    chk1("bp_rsp_valid", rsp_valid, 1'b1);
    bp_pop = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
      if (rsp_valid) bp_pop++;
    end
    chk("bp_pops", 32'(bp_pop), 32'd2);

    // Reset with one outstanding: outputs clear without a clock edge
    step(1'b1, 32'h1c000300, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    fq_valid = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    rsp_ready = 1'b0; flush = 1'b0;
    #1;
    chk1("pre_reset_busy", busy, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    step(1'b0, '0, 1'b0, 1'b1, 32'hBAD00000, 1'b1, 1'b0);
    step(1'b1, 32'h1c000400, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("post_reset_rsp_valid", rsp_valid, 1'b0);
    chk1("post_reset_accept", fq_ready, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h55AA55AA, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("post_reset_rsp_pc", rsp_pc, 32'h1c000400);
    chk("post_reset_rsp_inst", rsp_inst, 32'h55AA55AA);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 10) < 6, $urandom & 32'hFFFF_FFFC, $urandom % 2, $urandom % 2,
           $urandom, ($urandom % 10) < 7, ($urandom % 20) == 0);
    end
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
